// File: rtl/commit_trace_buffer.sv
// Commit-trace capture FIFO: filters GRF/DM write events from the core, stamps a
// sequence number and drains them over valid/ready; overflow drops, never stalls.
module commit_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter bit FILTER_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_wdata,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_type,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [15:0] out_seq,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + 32 + 32 + 32 + 16;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] TWO_C   = {{(AW-1){1'b0}}, 2'b10};

  // Adds 0..2 drops to the loss counter, pinning at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, wptr_inc;
  logic [AW:0]   count, count_nxt, free;
  logic [15:0]   seq_next;

  logic          grf_acc, grf_push, dm_push, pop;
  logic [1:0]    n_push, n_drop, seq_adv;
  logic [15:0]   grf_seq, dm_seq;
  logic [EW-1:0] grf_entry, dm_entry, wr0_data, wr1_data, head;
  logic          wr0_en, wr1_en;

  always_comb begin
    grf_acc   = grf_we & ~(FILTER_ZERO & (grf_addr == 5'd0));
    pop       = (count != '0) & out_ready;
    free      = DEPTH_C - count + {{AW{1'b0}}, pop};
    grf_push  = grf_acc & (free != '0);
    dm_push   = dm_we & (free >= (grf_acc ? TWO_C : ONE_C));
    n_push    = {1'b0, grf_push} + {1'b0, dm_push};
    n_drop    = {1'b0, grf_acc & ~grf_push} + {1'b0, dm_we & ~dm_push};
    seq_adv   = {1'b0, grf_acc} + {1'b0, dm_we};
    grf_seq   = seq_next;
    dm_seq    = seq_next + {15'b0, grf_acc};
    grf_entry = {1'b0, grf_pc, {27'b0, grf_addr}, grf_wdata, grf_seq};
    dm_entry  = {1'b1, dm_pc, dm_addr, dm_wdata, dm_seq};
    // GRF always takes the first slot when both are enqueued.
    wr0_en    = grf_push | dm_push;
    wr0_data  = grf_push ? grf_entry : dm_entry;
    wr1_en    = grf_push & dm_push;
    wr1_data  = dm_entry;
    wptr_inc  = wptr + 1'b1;
    count_nxt = count + {{(AW-1){1'b0}}, n_push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      seq_next <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wptr     <= wptr + {{(AW-1){1'b0}}, n_push};
      rptr     <= rptr + {{(AW-1){1'b0}}, pop};
      count    <= count_nxt;
      seq_next <= seq_next + {14'b0, seq_adv};
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= sat_add16(drop_cnt, n_drop);
      end
    end
  end

  // Storage is data only; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr] <= wr0_data;
    if (wr1_en) mem[wptr_inc] <= wr1_data;
  end

  always_comb begin
    head      = mem[rptr];
    out_valid = (count != '0);
    {out_type, out_pc, out_addr, out_data, out_seq} = out_valid ? head : '0;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: two DEPTH=4 instances sharing stimulus,
// one filtering register-0 writes and one recording them.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        grf_we = 1'b0, dm_we = 1'b0, out_ready = 1'b0;
  logic [31:0] grf_pc = '0, grf_wdata = '0, dm_pc = '0, dm_addr = '0, dm_wdata = '0;
  logic [4:0]  grf_addr = '0;

  logic        a_valid, a_type, a_ovf, b_valid, b_type, b_ovf;
  logic [31:0] a_pc, a_addr, a_data, b_pc, b_addr, b_data;
  logic [15:0] a_seq, a_drop, b_seq, b_drop;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(4), .FILTER_ZERO(1'b1)) u_a (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(a_valid), .out_ready(out_ready), .out_type(a_type), .out_pc(a_pc),
    .out_addr(a_addr), .out_data(a_data), .out_seq(a_seq),
    .overflow(a_ovf), .drop_cnt(a_drop));

  commit_trace_buffer #(.DEPTH(4), .FILTER_ZERO(1'b0)) u_b (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(b_valid), .out_ready(out_ready), .out_type(b_type), .out_pc(b_pc),
    .out_addr(b_addr), .out_data(b_data), .out_seq(b_seq),
    .overflow(b_ovf), .drop_cnt(b_drop));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    grf_we = 1'b0; dm_we = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs(); out_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_grf(input logic [4:0] a, input logic [31:0] pc, input logic [31:0] d);
    grf_we = 1'b1; grf_addr = a; grf_pc = pc; grf_wdata = d;
  endtask

  task automatic set_dm(input logic [31:0] a, input logic [31:0] pc, input logic [31:0] d);
    dm_we = 1'b1; dm_addr = a; dm_pc = pc; dm_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    n_cmp++; if (a_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b want 0", a_valid); end
    n_cmp++; if (a_ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow got %b want 0", a_ovf); end
    n_cmp++; if (a_drop !== 16'h0)  begin n_fail++; $display("FAIL reset_drop got %h want 0", a_drop); end
    n_cmp++; if (a_pc !== 32'h0)    begin n_fail++; $display("FAIL reset_pc got %h want 0", a_pc); end
    n_cmp++; if (a_seq !== 16'h0)   begin n_fail++; $display("FAIL reset_seq got %h want 0", a_seq); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_grf();
    do_reset();
    out_ready = 1'b1;
    set_grf(5'd8, 32'h3000, 32'h1234);
    tick();
    idle_inputs();
    n_cmp++; if (a_valid !== 1'b1)       begin n_fail++; $display("FAIL single_valid got %b want 1", a_valid); end
    n_cmp++; if (a_type !== 1'b0)        begin n_fail++; $display("FAIL single_type got %b want 0", a_type); end
    n_cmp++; if (a_pc !== 32'h3000)      begin n_fail++; $display("FAIL single_pc got %h want 3000", a_pc); end
    n_cmp++; if (a_addr !== 32'h8)       begin n_fail++; $display("FAIL single_addr got %h want 8", a_addr); end
    n_cmp++; if (a_data !== 32'h1234)    begin n_fail++; $display("FAIL single_data got %h want 1234", a_data); end
    n_cmp++; if (a_seq !== 16'h0)        begin n_fail++; $display("FAIL single_seq got %h want 0", a_seq); end
    tick();
    n_cmp++; if (a_valid !== 1'b0)       begin n_fail++; $display("FAIL single_drained got %b want 0", a_valid); end
    n_cmp++; if (a_pc !== 32'h0)         begin n_fail++; $display("FAIL single_zero_pc got %h want 0", a_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_grf(5'd3, 32'h100, 32'h55);
    set_dm(32'h10, 32'h104, 32'hAB);
    tick();
    idle_inputs();
    n_cmp++; if (a_type !== 1'b0)        begin n_fail++; $display("FAIL simul_head_type got %b want 0", a_type); end
    n_cmp++; if (a_seq !== 16'h0)        begin n_fail++; $display("FAIL simul_head_seq got %h want 0", a_seq); end
    n_cmp++; if (a_addr !== 32'h3)       begin n_fail++; $display("FAIL simul_head_addr got %h want 3", a_addr); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (a_valid !== 1'b1)       begin n_fail++; $display("FAIL simul_second_valid got %b want 1", a_valid); end
    n_cmp++; if (a_type !== 1'b1)        begin n_fail++; $display("FAIL simul_second_type got %b want 1", a_type); end
    n_cmp++; if (a_addr !== 32'h10)      begin n_fail++; $display("FAIL simul_second_addr got %h want 10", a_addr); end
    n_cmp++; if (a_data !== 32'hAB)      begin n_fail++; $display("FAIL simul_second_data got %h want ab", a_data); end
    n_cmp++; if (a_pc !== 32'h104)       begin n_fail++; $display("FAIL simul_second_pc got %h want 104", a_pc); end
    n_cmp++; if (a_seq !== 16'h1)        begin n_fail++; $display("FAIL simul_second_seq got %h want 1", a_seq); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (a_valid !== 1'b0)       begin n_fail++; $display("FAIL simul_empty got %b want 0", a_valid); end
  endtask

  task automatic test_filter();
    do_reset();
    set_grf(5'd0, 32'h200, 32'hDEAD);
    tick();
    idle_inputs();
    n_cmp++; if (a_valid !== 1'b0)       begin n_fail++; $display("FAIL filter_on_valid got %b want 0", a_valid); end
    n_cmp++; if (a_drop !== 16'h0)       begin n_fail++; $display("FAIL filter_on_drop got %h want 0", a_drop); end
    n_cmp++; if (b_valid !== 1'b1)       begin n_fail++; $display("FAIL filter_off_valid got %b want 1", b_valid); end
    n_cmp++; if (b_addr !== 32'h0)       begin n_fail++; $display("FAIL filter_off_addr got %h want 0", b_addr); end
    n_cmp++; if (b_data !== 32'hDEAD)    begin n_fail++; $display("FAIL filter_off_data got %h want dead", b_data); end
    set_grf(5'd5, 32'h204, 32'h77);
    tick();
    idle_inputs();
    n_cmp++; if (a_addr !== 32'h5)       begin n_fail++; $display("FAIL filter_next_addr got %h want 5", a_addr); end
    n_cmp++; if (a_seq !== 16'h0)        begin n_fail++; $display("FAIL filter_next_seq got %h want 0", a_seq); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_grf(5'(i + 1), 32'h400 + 32'(i), 32'(i));
      tick();
    end
    idle_inputs();
    n_cmp++; if (a_ovf !== 1'b1)         begin n_fail++; $display("FAIL ovf_flag got %b want 1", a_ovf); end
    n_cmp++; if (a_drop !== 16'd2)       begin n_fail++; $display("FAIL ovf_drop got %0d want 2", a_drop); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (a_seq !== 16'(i))     begin n_fail++; $display("FAIL ovf_drain_seq got %0d want %0d", a_seq, i); end
      n_cmp++; if (a_data !== 32'(i))    begin n_fail++; $display("FAIL ovf_drain_data got %0d want %0d", a_data, i); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (a_valid !== 1'b0)       begin n_fail++; $display("FAIL ovf_drained got %b want 0", a_valid); end
    set_grf(5'd7, 32'h500, 32'h5);
    tick();
    idle_inputs();
    n_cmp++; if (a_seq !== 16'd6)        begin n_fail++; $display("FAIL ovf_next_seq got %0d want 6", a_seq); end
    n_cmp++; if (a_ovf !== 1'b1)         begin n_fail++; $display("FAIL ovf_sticky got %b want 1", a_ovf); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_grf(5'(i + 1), 32'h600, 32'(i));
      tick();
    end
    out_ready = 1'b1;
    set_grf(5'd9, 32'h700, 32'h99);
    set_dm(32'h20, 32'h704, 32'h77);
    tick();
    idle_inputs();
    out_ready = 1'b0;
    n_cmp++; if (a_drop !== 16'd1)       begin n_fail++; $display("FAIL full_drop got %0d want 1", a_drop); end
    n_cmp++; if (a_ovf !== 1'b1)         begin n_fail++; $display("FAIL full_ovf got %b want 1", a_ovf); end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (a_valid !== 1'b1)     begin n_fail++; $display("FAIL full_drain_valid got %b want 1", a_valid); end
      n_cmp++; if (a_seq !== 16'(i))     begin n_fail++; $display("FAIL full_drain_seq got %0d want %0d", a_seq, i); end
      if (i == 4) begin
        n_cmp++; if (a_type !== 1'b0)    begin n_fail++; $display("FAIL full_last_type got %b want 0", a_type); end
        n_cmp++; if (a_data !== 32'h99)  begin n_fail++; $display("FAIL full_last_data got %h want 99", a_data); end
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (a_valid !== 1'b0)       begin n_fail++; $display("FAIL full_count got %b want 0", a_valid); end
    set_dm(32'h30, 32'h800, 32'h1);
    tick();
    idle_inputs();
    n_cmp++; if (a_seq !== 16'd6)        begin n_fail++; $display("FAIL full_next_seq got %0d want 6", a_seq); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_grf(5'(i + 10), 32'h900, 32'(i + 100));
      tick();
      n_cmp++; if (a_valid !== 1'b1)     begin n_fail++; $display("FAIL b2b_valid got %b want 1", a_valid); end
      n_cmp++; if (a_seq !== 16'(i))     begin n_fail++; $display("FAIL b2b_seq got %0d want %0d", a_seq, i); end
    end
    idle_inputs();
    tick();
    out_ready = 1'b0;
    n_cmp++; if (a_valid !== 1'b0)       begin n_fail++; $display("FAIL b2b_empty got %b want 0", a_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_grf(5'(i + 1), 32'hA00, 32'(i));
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (a_seq !== 16'd1)        begin n_fail++; $display("FAIL mid_pre_seq got %0d want 1", a_seq); end
    n_cmp++; if (a_ovf !== 1'b1)         begin n_fail++; $display("FAIL mid_pre_ovf got %b want 1", a_ovf); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (a_valid !== 1'b0)       begin n_fail++; $display("FAIL mid_valid got %b want 0", a_valid); end
    n_cmp++; if (a_ovf !== 1'b0)         begin n_fail++; $display("FAIL mid_ovf got %b want 0", a_ovf); end
    n_cmp++; if (a_drop !== 16'h0)       begin n_fail++; $display("FAIL mid_drop got %0d want 0", a_drop); end
    #2 reset = 1'b0;
    tick();
    set_grf(5'd4, 32'hB00, 32'hB);
    tick();
    idle_inputs();
    n_cmp++; if (a_valid !== 1'b1)       begin n_fail++; $display("FAIL mid_after_valid got %b want 1", a_valid); end
    n_cmp++; if (a_seq !== 16'h0)        begin n_fail++; $display("FAIL mid_after_seq got %0d want 0", a_seq); end
    n_cmp++; if (a_pc !== 32'hB00)       begin n_fail++; $display("FAIL mid_after_pc got %h want b00", a_pc); end
  endtask

  initial begin
    test_reset();
    test_single_grf();
    test_simultaneous();
    test_filter();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
